// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode and sequencer state encodings,
// plus the request-to-result latency of the iterative multiply/divide unit.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_XNOR = 4'b0101,
    ALU_LSL  = 4'b0110,
    ALU_LSR  = 4'b0111,
    ALU_SLT  = 4'b1001,
    ALU_SLTU = 4'b1010,
    ALU_MULU = 4'b1011,
    ALU_DIVU = 4'b1100
  } aluop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  // Cycles from the accepting edge to the result strobe: WIDTH iterations plus DONE.
  function automatic int ALU_MULDIV_LAT(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/result bundle of alu_mc: valid/ready request side, single-cycle
// result strobe with no backpressure on the result side.
interface alu_mc_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) ();
  logic             op_valid;
  logic             op_ready;
  aluop_t           opcode;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             res_valid;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_hi;
  logic             flag_n;
  logic             flag_z;
  logic             flag_v;

  modport master (
    output op_valid, opcode, op1, op2,
    input  op_ready, res_valid, res, res_hi, flag_n, flag_z, flag_v
  );

  modport slave (
    input  op_valid, opcode, op1, op2,
    output op_ready, res_valid, res, res_hi, flag_n, flag_z, flag_v
  );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per step;
// done flags the last step, whose next-state values are the final result.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic             ovf,
  output logic [WIDTH-1:0] nxt_lo,
  output logic [WIDTH-1:0] nxt_hi
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;

  logic [WIDTH:0]   sum, shl;
  logic [WIDTH-1:0] diff, step_hi, step_lo;
  logic             ge;

  always_comb begin
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    // Divide: remainder shifts left, pulling in the next dividend bit from lo.
    shl  = {hi_q, lo_q[WIDTH-1]};
    ge   = (shl >= {1'b0, b_q});
    diff = shl[WIDTH-1:0] - b_q;
    if (div_q) begin
      step_hi = ge ? diff : shl[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], ge};
    end else begin
      step_hi = sum[WIDTH:1];
      step_lo = {sum[0], lo_q[WIDTH-1:1]};
    end

    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
    div_d = div_q;
    cnt_d = cnt_q;
    if (start) begin
      hi_d  = '0;
      lo_d  = a;
      b_d   = b;
      div_d = is_div;
      cnt_d = CW'(WIDTH - 1);
    end else if (step) begin
      hi_d = step_hi;
      lo_d = step_lo;
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  assign done   = step && (cnt_q == '0);
  assign ovf    = div_q && (b_q == '0);
  assign nxt_lo = step_lo;
  assign nxt_hi = step_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops at full rate, MULU/DIVU via alu_muldiv when
// ALU_MULDIV_EN is defined (otherwise illegal); result strobe has no backpressure.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic     CLK,
  input logic     nRST,
  alu_mc_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d, res_hi_q, res_hi_d;
  logic             res_valid_q, res_valid_d;
  logic             flag_n_q, flag_n_d, flag_z_q, flag_z_d, flag_v_q, flag_v_d;

  logic [WIDTH-1:0] sum, diff, sc_res;
  logic [SHW-1:0]   shamt;
  logic             sc_v;

  logic             is_md, md_start, md_step, md_done, md_ovf;
  logic [WIDTH-1:0] md_lo, md_hi;

  always_comb begin
    sum    = bus.op1 + bus.op2;
    diff   = bus.op1 - bus.op2;
    shamt  = bus.op2[SHW-1:0];
    sc_res = '0;
    sc_v   = 1'b0;
    case (bus.opcode)
      ALU_ADD: begin
        sc_res = sum;
        sc_v   = (bus.op1[WIDTH-1] == bus.op2[WIDTH-1]) && (sum[WIDTH-1] != bus.op1[WIDTH-1]);
      end
      ALU_SUB: begin
        sc_res = diff;
        sc_v   = (bus.op1[WIDTH-1] != bus.op2[WIDTH-1]) && (diff[WIDTH-1] != bus.op1[WIDTH-1]);
      end
      ALU_AND:  sc_res = bus.op1 & bus.op2;
      ALU_OR:   sc_res = bus.op1 | bus.op2;
      ALU_XOR:  sc_res = bus.op1 ^ bus.op2;
      ALU_XNOR: sc_res = ~(bus.op1 ^ bus.op2);
      ALU_LSL:  sc_res = bus.op1 << shamt;
      ALU_LSR:  sc_res = bus.op1 >> shamt;
      ALU_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(bus.op1) < $signed(bus.op2)};
      ALU_SLTU: sc_res = {{(WIDTH-1){1'b0}}, bus.op1 < bus.op2};
      default:  ;
    endcase
  end

`ifdef ALU_MULDIV_EN
  assign is_md = (bus.opcode == ALU_MULU) || (bus.opcode == ALU_DIVU);

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (CLK),
    .rst_n  (nRST),
    .start  (md_start),
    .step   (md_step),
    .is_div (bus.opcode == ALU_DIVU),
    .a      (bus.op1),
    .b      (bus.op2),
    .done   (md_done),
    .ovf    (md_ovf),
    .nxt_lo (md_lo),
    .nxt_hi (md_hi)
  );
`else
  logic unused_md;
  assign is_md     = 1'b0;
  assign md_done   = 1'b0;
  assign md_ovf    = 1'b0;
  assign md_lo     = '0;
  assign md_hi     = '0;
  assign unused_md = md_start | md_step;
`endif

  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    res_hi_d    = res_hi_q;
    flag_n_d    = flag_n_q;
    flag_z_d    = flag_z_q;
    flag_v_d    = flag_v_q;
    res_valid_d = 1'b0;
    md_start    = 1'b0;
    md_step     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.op_valid) begin
          if (is_md) begin
            md_start = 1'b1;
            state_d  = ITER;
          end else begin
            res_d       = sc_res;
            res_hi_d    = '0;
            flag_n_d    = sc_res[WIDTH-1];
            flag_z_d    = (sc_res == '0);
            flag_v_d    = sc_v;
            res_valid_d = 1'b1;
          end
        end
      end
      ITER: begin
        md_step = 1'b1;
        // Load outputs on the last step so they are already valid during DONE.
        if (md_done) begin
          state_d     = DONE;
          res_d       = md_lo;
          res_hi_d    = md_hi;
          flag_n_d    = md_lo[WIDTH-1];
          flag_z_d    = (md_lo == '0);
          flag_v_d    = md_ovf;
          res_valid_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      res_q       <= '0;
      res_hi_q    <= '0;
      res_valid_q <= 1'b0;
      flag_n_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_v_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      res_hi_q    <= res_hi_d;
      res_valid_q <= res_valid_d;
      flag_n_q    <= flag_n_d;
      flag_z_q    <= flag_z_d;
      flag_v_q    <= flag_v_d;
    end
  end

  assign bus.op_ready  = (state_q == IDLE);
  assign bus.res_valid = res_valid_q;
  assign bus.res       = res_q;
  assign bus.res_hi    = res_hi_q;
  assign bus.flag_n    = flag_n_q;
  assign bus.flag_z    = flag_z_q;
  assign bus.flag_v    = flag_v_q;
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=32): directed and random ops against an arithmetic model;
// MULU/DIVU expectations follow whether ALU_MULDIV_EN is defined.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W = 32;
`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_mc_if #(.WIDTH(W)) bus ();
  alu_mc #(.WIDTH(W)) dut (.CLK(CLK), .nRST(nRST), .bus(bus.slave));

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op_valid = v;
    bus.opcode   = aluop_t'(op);
    bus.op1      = a;
    bus.op2      = b;
  endtask

  // {res, res_hi, n, z, v}
  function automatic logic [66:0] obs();
    return {bus.res, bus.res_hi, bus.flag_n, bus.flag_z, bus.flag_v};
  endfunction

  function automatic logic [66:0] ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r, h;
    logic        v;
    longint      s;
    logic [63:0] p;
    r = 0; h = 0; v = 0;
    case (op)
      4'd0: begin r = a + b; s = longint'($signed(a)) + longint'($signed(b));
                  v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd1: begin r = a - b; s = longint'($signed(a)) - longint'($signed(b));
                  v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~(a ^ b);
      4'd6: r = a << (b % 32);
      4'd7: r = a >> (b % 32);
      4'd9: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10: r = (a < b) ? 32'd1 : 32'd0;
      4'd11: if (MD) begin p = 64'(a) * 64'(b); r = p[31:0]; h = p[63:32]; end
      4'd12: if (MD) begin
               if (b == 0) begin r = 32'hFFFF_FFFF; h = a; v = 1; end
               else begin r = a / b; h = a % b; end
             end
      default: ;
    endcase
    return {r, h, r[31], (r == 0), v};
  endfunction

  task automatic test_reset;
    drive(0, 0, 0, 0);
    nRST = 1'b0;
    #1;
    n_cmp++;
    if (bus.op_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", bus.op_ready); end
    n_cmp++;
    if ({bus.res_valid, obs()} !== 68'd0) begin n_bad++; $display("FAIL reset_outs got=%h want=0", {bus.res_valid, obs()}); end
    repeat (3) tick;
    nRST = 1'b1;
    tick;
    n_cmp++;
    if ({bus.op_ready, bus.res_valid, obs()} !== {1'b1, 68'd0}) begin
      n_bad++; $display("FAIL post_reset got=%h want=%h", {bus.op_ready, bus.res_valid, obs()}, {1'b1, 68'd0});
    end
  endtask

  task automatic test_add_ovf;
    drive(1, 4'd0, 32'h7FFF_FFFF, 32'h1);
    tick;
    drive(0, 0, 0, 0);
    n_cmp++;
    if ({bus.res_valid, obs()} !== {1'b1, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL add_ovf got=%h want=%h", {bus.res_valid, obs()}, {1'b1, 32'h8000_0000, 32'h0, 3'b101});
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_r[3];
    exp_r[0] = 32'h0; exp_r[1] = 32'h1; exp_r[2] = 32'h4000_0000;
    drive(1, 4'd1, 32'd5, 32'd5);
    tick;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(1, 4'd9, 32'hFFFF_FFFF, 32'd1);
      else if (i == 1) drive(1, 4'd7, 32'h8000_0000, 32'h21);
      else drive(0, 0, 0, 0);
      n_cmp++;
      if ({bus.res_valid, bus.res, bus.flag_z} !== {1'b1, exp_r[i], exp_r[i] == 0}) begin
        n_bad++; $display("FAIL b2b_%0d got v=%b res=%h z=%b want res=%h", i, bus.res_valid, bus.res, bus.flag_z, exp_r[i]);
      end
      tick;
    end
    n_cmp++;
    if (bus.res_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drop got=%b want=0", bus.res_valid); end
  endtask

  task automatic test_random_single;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [66:0] held, exp;
    logic        v, exp_v;
    held = obs();
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      if (MD && (op == 4'd11 || op == 4'd12)) op = 4'd0;
      a = $urandom; b = $urandom;
      if (i % 7 == 0) b = a;
      if (i % 11 == 0) a = 32'h8000_0000;
      v = ($urandom_range(0, 4) != 0);
      n_cmp++;
      if (bus.op_ready !== 1'b1) begin n_bad++; $display("FAIL rnd_ready[%0d] got=%b want=1", i, bus.op_ready); end
      drive(v, op, a, b);
      exp_v = v;
      if (v) held = ref_op(op, a, b);
      exp = held;
      tick;
      n_cmp++;
      if ({bus.res_valid, obs()} !== {exp_v, exp}) begin
        n_bad++; $display("FAIL rnd[%0d] op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, {bus.res_valid, obs()}, {exp_v, exp});
      end
    end
    drive(0, 0, 0, 0);
    tick;
  endtask

`ifdef ALU_MULDIV_EN
  task automatic test_muldiv;
    logic [3:0]  ops[10];
    logic [31:0] as[10], bs[10];
    logic [66:0] exp;
    ops[0] = 4'd11; as[0] = 32'hFFFF_FFFF; bs[0] = 32'hFFFF_FFFF;
    ops[1] = 4'd12; as[1] = 32'd100;       bs[1] = 32'd7;
    ops[2] = 4'd12; as[2] = 32'd9;         bs[2] = 32'd0;
    for (int j = 3; j < 10; j++) begin
      ops[j] = (j % 2) ? 4'd11 : 4'd12;
      as[j]  = $urandom;
      bs[j]  = (j == 8) ? 32'd0 : ((j % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
    end
    for (int j = 0; j < 10; j++) begin
      exp = ref_op(ops[j], as[j], bs[j]);
      drive(1, ops[j], as[j], bs[j]);
      tick;
      for (int c = 1; c <= W + 1; c++) begin
        drive(c <= W, 4'd0, 32'd1, 32'd2);
        n_cmp++;
        if ({bus.op_ready, bus.res_valid} !== {1'b0, c == W + 1}) begin
          n_bad++; $display("FAIL md%0d_cyc%0d ready/valid got=%b%b want=0%b", j, c, bus.op_ready, bus.res_valid, c == W + 1);
        end
        if (c == W + 1) begin
          n_cmp++;
          if (obs() !== exp) begin
            n_bad++; $display("FAIL md%0d op=%0d a=%h b=%h got=%h want=%h", j, ops[j], as[j], bs[j], obs(), exp);
          end
        end
        tick;
      end
      n_cmp++;
      if ({bus.op_ready, bus.res_valid} !== 2'b10) begin
        n_bad++; $display("FAIL md%0d_after got=%b%b want=10", j, bus.op_ready, bus.res_valid);
      end
    end
  endtask
`else
  task automatic test_muldiv;
    for (int j = 0; j < 2; j++) begin
      drive(1, j ? 4'd12 : 4'd11, 32'd3, 32'd4);
      tick;
      drive(0, 0, 0, 0);
      n_cmp++;
      if ({bus.op_ready, bus.res_valid, obs()} !== {1'b1, 1'b1, 64'd0, 3'b010}) begin
        n_bad++; $display("FAIL md_illegal%0d got=%h want=%h", j, {bus.op_ready, bus.res_valid, obs()}, {2'b11, 64'd0, 3'b010});
      end
      tick;
      n_cmp++;
      if ({bus.op_ready, bus.res_valid} !== 2'b10) begin
        n_bad++; $display("FAIL md_illegal%0d_after got=%b%b want=10", j, bus.op_ready, bus.res_valid);
      end
    end
  endtask
`endif

  task automatic test_reset_mid_iter;
    drive(1, 4'd0, 32'd5, 32'd6);
    tick;
    n_cmp++;
    if ({bus.res_valid, bus.res} !== {1'b1, 32'd11}) begin
      n_bad++; $display("FAIL rst_pre got v=%b res=%h want v=1 res=b", bus.res_valid, bus.res);
    end
    drive(1, 4'd11, 32'd3, 32'd4);
    tick;
    drive(0, 0, 0, 0);
    for (int i = 1; i < 10; i++) begin
      n_cmp++;
      if (bus.res_valid !== (!MD && i == 1)) begin
        n_bad++; $display("FAIL rst_iter%0d valid got=%b want=%b", i, bus.res_valid, !MD && i == 1);
      end
      tick;
    end
    nRST = 1'b0;
    #1;
    n_cmp++;
    if ({bus.op_ready, bus.res_valid, obs()} !== {1'b1, 68'd0}) begin
      n_bad++; $display("FAIL rst_mid got=%h want=%h", {bus.op_ready, bus.res_valid, obs()}, {1'b1, 68'd0});
    end
    tick;
    nRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++;
      if ({bus.op_ready, bus.res_valid} !== 2'b10) begin
        n_bad++; $display("FAIL rst_idle%0d got=%b%b want=10", i, bus.op_ready, bus.res_valid);
      end
    end
    drive(1, 4'd0, 32'd1, 32'd2);
    tick;
    drive(0, 0, 0, 0);
    n_cmp++;
    if ({bus.res_valid, obs()} !== {1'b1, 32'd3, 32'd0, 3'b000}) begin
      n_bad++; $display("FAIL rst_add got=%h want=%h", {bus.res_valid, obs()}, {1'b1, 32'd3, 32'd0, 3'b000});
    end
  endtask

  initial begin
    test_reset;
    test_add_ovf;
    test_back_to_back;
    test_random_single;
    test_muldiv;
    test_reset_mid_iter;
    test_random_single;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
